prog_loader: RTL

Boot-time program loader sitting directly upstream of the processor core. Accepts a stream of 9-bit machine words over a valid/ready handshake and writes them into an internal instruction RAM. Holds the core in reset until loading completes, then serves `mach_code` to the core's fetch stage from `prog_ctr`. It also watches the core's `done` and measures run length in cycles.

---
 rtl/prog_loader_pkg.sv | 10 +
 rtl/prog_loader_instr_ram.sv | 22 ++
 rtl/prog_loader.sv | 108 ++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, FIN} loader_state_t;

  localparam int              CYC_W    = 16;
  localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};
  localparam int              NOP_WORD = 0;

endpackage

// File: rtl/prog_loader_instr_ram.sv
// Instruction RAM: 2^D x W, one synchronous write port and one combinational read port.
module instr_ram #(
  parameter int D = 12,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         we,
  input  logic [D-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [D-1:0] raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [2**D];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Boot loader: streams words into instr_ram, holds the core in reset until the image is complete.
// Optional run-length counter enabled by defining PROG_LOADER_CYCLE_CNT_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int D = 12,
  parameter int W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             core_reset,
  input  logic [D-1:0]     prog_ctr,
  output logic [W-1:0]     mach_code,
  input  logic             core_done,
  output logic             loaded,
  output logic             truncated,
  output logic [D:0]       word_count,
  output logic [CYC_W-1:0] run_cycles,
  output logic             finished
);

  loader_state_t state;
  logic [D-1:0]  waddr;
  logic [W-1:0]  ram_rdata;
  logic          accept;

  // in_ready is only high in IDLE/LOAD, so accept alone qualifies a write
  assign accept = in_valid & in_ready;
  assign waddr  = word_count[D-1:0];

  instr_ram #(.D(D), .W(W)) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (waddr),
    .wdata (in_data),
    .raddr (prog_ctr),
    .rdata (ram_rdata)
  );

  // Stale RAM beyond the loaded image reads back as NOP
  assign mach_code = ({1'b0, prog_ctr} < word_count) ? ram_rdata : W'(NOP_WORD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      core_reset <= 1'b1;
      loaded     <= 1'b0;
      truncated  <= 1'b0;
      word_count <= '0;
      finished   <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            word_count <= word_count + 1'b1;
            if (in_last) begin
              state    <= HOLD;
              in_ready <= 1'b0;
            end else if (&waddr) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              truncated <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        HOLD: begin
          loaded     <= 1'b1;
          core_reset <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          if (core_done) begin
            state    <= FIN;
            finished <= 1'b1;
          end
        end
        FIN:     ;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PROG_LOADER_CYCLE_CNT_EN
  logic [CYC_W-1:0] cyc_q;

  // Counted on RUN entry and on each RUN cycle without done, so the total
  // equals the number of RUN cycles including the one that observes done.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
    end else if ((state == HOLD) || (state == RUN && !core_done)) begin
      if (cyc_q != CYC_MAX) cyc_q <= cyc_q + 1'b1;
    end
  end

  assign run_cycles = cyc_q;
`else
  assign run_cycles = '0;
`endif

endmodule
